// File: rtl/xera4_video_scanout.sv
// XERA4 video scanout: raster timing, 1 bpp bitmap fetch and MSB-first pixel serialiser.
// Optional macro XERA4_SCANOUT_VBLANK_IRQ_EN adds a one-clock vblank_irq output.
module xera4_video_scanout #(
    parameter int          H_ACTIVE  = 256,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 32,
    parameter int          H_BP      = 16,
    parameter int          V_ACTIVE  = 192,
    parameter int          V_FP      = 20,
    parameter int          V_SYNC    = 3,
    parameter int          V_BP      = 47,
    parameter logic [14:0] BASE_ADDR = 15'h0000,
    parameter logic [7:0]  FG_COLOR  = 8'hFF,
    parameter logic [7:0]  BG_COLOR  = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [14:0] Scan_Add,
    output logic        Scan_re,
    input  logic [7:0]  Scan_In,
    output logic [7:0]  rgb,
    output logic        de,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic [7:0]  frame_cnt
`ifdef XERA4_SCANOUT_VBLANK_IRQ_EN
    ,
    output logic        vblank_irq
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam logic [14:0] LINE_STEP = 15'(H_ACTIVE / 8);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [14:0]   line_base;
    logic [14:0]   scan_add_q;
    logic [14:0]   fetch_addr;
    logic [7:0]    shift_q;
    logic [1:0]    de_pipe;
    logic [1:0]    hs_pipe;
    logic [1:0]    vs_pipe;
    logic          h_wrap, v_wrap, h_act, v_act;
    logic          fetch, load, hs_raw_n, vs_raw_n;

    assign h_wrap   = (h_cnt == HW'(H_TOTAL - 1));
    assign v_wrap   = h_wrap && (v_cnt == VW'(V_TOTAL - 1));
    assign h_act    = (h_cnt < HW'(H_ACTIVE));
    assign v_act    = (v_cnt < VW'(V_ACTIVE));
    assign fetch    = h_act && v_act && (h_cnt[2:0] == 3'd0);
    assign load     = h_act && v_act && (h_cnt[2:0] == 3'd1);
    assign hs_raw_n = !((h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_raw_n = !((v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)));

    // The address is presented in the same cycle the counters reach the byte
    // boundary so the RAM's registered data is ready for the load one clock later.
    // NOTE: gating with rst_n keeps the strobe and address at their reset values while reset is held.
    assign fetch_addr = line_base + 15'(h_cnt >> 3);
    assign Scan_re    = rst_n && fetch;
    assign Scan_Add   = Scan_re ? fetch_addr : scan_add_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            line_base <= BASE_ADDR;
            frame_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
                if (v_wrap)
                    line_base <= BASE_ADDR;
                else if (v_act)
                    line_base <= line_base + LINE_STEP;
            end
            if (v_wrap)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Two-stage alignment: load/shift plus the decode pipes give the fixed 2-clock latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_add_q <= '0;
            shift_q    <= '0;
            de_pipe    <= '0;
            hs_pipe    <= '1;
            vs_pipe    <= '1;
        end else begin
            if (fetch)
                scan_add_q <= fetch_addr;
            shift_q <= load ? Scan_In : {shift_q[6:0], 1'b0};
            de_pipe <= {de_pipe[0], h_act && v_act};
            hs_pipe <= {hs_pipe[0], hs_raw_n};
            vs_pipe <= {vs_pipe[0], vs_raw_n};
        end
    end

    assign de      = de_pipe[1];
    assign hsync_n = hs_pipe[1];
    assign vsync_n = vs_pipe[1];
    assign rgb     = de ? (shift_q[7] ? FG_COLOR : BG_COLOR) : 8'h00;

`ifdef XERA4_SCANOUT_VBLANK_IRQ_EN
    logic [1:0] irq_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq_pipe <= '0;
        else
            irq_pipe <= {irq_pipe[0], (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE))};
    end

    assign vblank_irq = irq_pipe[1];
`endif

endmodule

// File: tb/tb_xera4_video_scanout.sv
// Bench for xera4_video_scanout: random bitmap RAM, full-frame cycle-by-cycle reference model,
// a second instance with a wrapping base address and a mid-line reset.
module tb_xera4_video_scanout;

    localparam int H_ACTIVE = 256, H_FP = 16, H_SYNC = 32, H_BP = 16;
    localparam int V_ACTIVE = 192, V_FP = 20, V_SYNC = 3, V_BP = 47;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int LINE_B   = H_ACTIVE / 8;
    localparam logic [14:0] BASE_A = 15'h0000;
    localparam logic [14:0] BASE_B = 15'h7FF0;

    typedef struct packed {
        logic [14:0] add;
        logic        re;
        logic [7:0]  rgb;
        logic        de;
        logic        hs_n;
        logic        vs_n;
        logic [7:0]  fc;
        logic        irq;
    } obs_t;

    localparam obs_t RESET_OBS = '{add: 15'h0, re: 1'b0, rgb: 8'h00, de: 1'b0,
                                   hs_n: 1'b1, vs_n: 1'b1, fc: 8'h00, irq: 1'b0};

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n;
    logic [14:0] add_a, add_b;
    logic        re_a, re_b, de_a, de_b, hs_a, hs_b, vs_a, vs_b, irq_a, irq_b;
    logic [7:0]  in_a, in_b, rgb_a, rgb_b, fc_a, fc_b;
    logic [7:0]  mem [32768];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Synchronous RAM read port for each instance, reading every cycle.
    always @(posedge clk) begin
        in_a <= mem[add_a];
        in_b <= mem[add_b];
    end

    xera4_video_scanout dut_a (
        .clk(clk), .rst_n(rst_a_n), .Scan_Add(add_a), .Scan_re(re_a), .Scan_In(in_a),
        .rgb(rgb_a), .de(de_a), .hsync_n(hs_a), .vsync_n(vs_a), .frame_cnt(fc_a)
`ifdef XERA4_SCANOUT_VBLANK_IRQ_EN
        , .vblank_irq(irq_a)
`endif
    );

    xera4_video_scanout #(.BASE_ADDR(BASE_B)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .Scan_Add(add_b), .Scan_re(re_b), .Scan_In(in_b),
        .rgb(rgb_b), .de(de_b), .hsync_n(hs_b), .vsync_n(vs_b), .frame_cnt(fc_b)
`ifdef XERA4_SCANOUT_VBLANK_IRQ_EN
        , .vblank_irq(irq_b)
`endif
    );

`ifndef XERA4_SCANOUT_VBLANK_IRQ_EN
    assign irq_a = 1'b0;
    assign irq_b = 1'b0;
`endif

    // Reference: n = rising edges since reset release. Counters read (n mod H_TOTAL, line);
    // the visible outputs describe the raster position two clocks earlier.
    function automatic obs_t model(input int n, input logic [14:0] base, input logic [14:0] held);
        obs_t e;
        int h, v, m, hx, vy;
        logic [7:0] byte_v;
        h      = n % H_TOTAL;
        v      = (n / H_TOTAL) % V_TOTAL;
        e.fc   = 8'((n / FRAME) % 256);
        e.re   = (v < V_ACTIVE) && (h < H_ACTIVE) && (h % 8 == 0);
        e.add  = e.re ? 15'((int'(base) + v * LINE_B + h / 8) % 32768) : held;
        m      = n - 2;
        if (m < 0) begin
            e.de = 1'b0; e.hs_n = 1'b1; e.vs_n = 1'b1; e.rgb = 8'h00; e.irq = 1'b0;
        end else begin
            hx     = m % H_TOTAL;
            vy     = (m / H_TOTAL) % V_TOTAL;
            e.de   = (hx < H_ACTIVE) && (vy < V_ACTIVE);
            e.hs_n = !((hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC));
            e.vs_n = !((vy >= V_ACTIVE + V_FP) && (vy < V_ACTIVE + V_FP + V_SYNC));
            e.irq  = (hx == 0) && (vy == V_ACTIVE);
            e.rgb  = 8'h00;
            if (e.de) begin
                byte_v = mem[15'((int'(base) + vy * LINE_B + hx / 8) % 32768)];
                e.rgb  = byte_v[7 - (hx % 8)] ? 8'hFF : 8'h00;
            end
        end
        return e;
    endfunction

    function automatic obs_t get_a();
        return '{add_a, re_a, rgb_a, de_a, hs_a, vs_a, fc_a, irq_a};
    endfunction

    function automatic obs_t get_b();
        return '{add_b, re_b, rgb_b, de_b, hs_b, vs_b, fc_b, irq_b};
    endfunction

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    task automatic check(input string who, input string field, input int n,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s n=%0d: observed %0h expected %0h", who, field, n, obs, exp);
        end
        if (errors >= 20) begin
            $display("FAIL abort: error limit reached");
            summary();
            $finish;
        end
    endtask

    task automatic compare_all(input string who, input int n, input obs_t got, input obs_t exp);
        check(who, "Scan_Add", n, 32'(got.add), 32'(exp.add));
        check(who, "Scan_re", n, 32'(got.re), 32'(exp.re));
        check(who, "rgb", n, 32'(got.rgb), 32'(exp.rgb));
        check(who, "de", n, 32'(got.de), 32'(exp.de));
        check(who, "hsync_n", n, 32'(got.hs_n), 32'(exp.hs_n));
        check(who, "vsync_n", n, 32'(got.vs_n), 32'(exp.vs_n));
        check(who, "frame_cnt", n, 32'(got.fc), 32'(exp.fc));
`ifdef XERA4_SCANOUT_VBLANK_IRQ_EN
        check(who, "vblank_irq", n, 32'(got.irq), 32'(exp.irq));
`endif
    endtask

    initial begin
        obs_t        e;
        logic [7:0]  px_a5 [8];
        logic [14:0] held_a, held_b;
        int          na, nb, b_reset_at, irq_count;
        bit          b_held;

        px_a5 = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF};
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
        mem[0]    = 8'hA5;
        mem[32]   = 8'h80;
        mem[6143] = 8'h01;

        repeat (3) @(negedge clk);
        compare_all("a.reset", -1, get_a(), RESET_OBS);
        compare_all("b.reset", -1, get_b(), RESET_OBS);

        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        na = 0; nb = 0; held_a = '0; held_b = '0; b_held = 1'b0; irq_count = 0;
        b_reset_at = 100 * H_TOTAL + int'($urandom_range(8, H_TOTAL - 8));
        #1;
        e = model(0, BASE_A, held_a); held_a = e.add; compare_all("a", 0, get_a(), e);
        e = model(0, BASE_B, held_b); held_b = e.add; compare_all("b", 0, get_b(), e);

        for (int c = 1; c <= FRAME + 400; c++) begin
            @(negedge clk);
            na++;
            e = model(na, BASE_A, held_a);
            held_a = e.add;
            compare_all("a", na, get_a(), e);
            if (na >= 2 && na <= 9)
                check("a", "px_a5", na, 32'(rgb_a), 32'(px_a5[na - 2]));
            if (na == H_TOTAL)
                check("a", "line1_addr", na, 32'(add_a), 32'h0020);
            if (na == H_TOTAL + 2)
                check("a", "px_0_1", na, 32'(rgb_a), 32'hFF);
            if (na == 191 * H_TOTAL + 257)
                check("a", "px_255_191", na, 32'(rgb_a), 32'hFF);
            if (na == FRAME - 1)
                check("a", "fc_before_wrap", na, 32'(fc_a), 32'h0);
            if (na == FRAME)
                check("a", "fc_after_wrap", na, 32'(fc_a), 32'h1);
            if (irq_a === 1'b1)
                irq_count++;

            if (!b_held) begin
                nb++;
                e = model(nb, BASE_B, held_b);
                held_b = e.add;
                compare_all("b", nb, get_b(), e);
                if (nb == H_TOTAL)
                    check("b", "line1_wrap_addr", nb, 32'(add_b), 32'h0010);
                if (c == b_reset_at) begin
                    rst_b_n = 1'b0;
                    #1;
                    compare_all("b.midreset", nb, get_b(), RESET_OBS);
                    b_held = 1'b1;
                end
            end else begin
                compare_all("b.held", nb, get_b(), RESET_OBS);
                rst_b_n = 1'b1;
                nb = 0;
                held_b = '0;
                #1;
                e = model(0, BASE_B, held_b);
                held_b = e.add;
                compare_all("b.restart", 0, get_b(), e);
                check("b", "restart_addr", 0, 32'(add_b), 32'(BASE_B));
                b_held = 1'b0;
            end
        end

`ifdef XERA4_SCANOUT_VBLANK_IRQ_EN
        check("a", "irq_pulses", na, 32'(irq_count), 32'd1);
`endif
        summary();
        $finish;
    end

endmodule
